// File: rtl/mulu_seq_shiftadd.sv
`default_nettype none
// ============================================================================
// mulu_seq_shiftadd : sequential unsigned shift-and-add multiplier
// Revision 1.0
// ============================================================================
module mulu_seq_shiftadd #(
   parameter int X_WIDTH = 3,
   parameter int Y_WIDTH = 3,
   parameter int P_WIDTH = X_WIDTH + Y_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [X_WIDTH-1:0] x,
   input  logic [Y_WIDTH-1:0] y,
   input  logic               start,
   output logic [P_WIDTH-1:0] p,
   output logic               rdy,
   output logic               busy
);

   localparam int CNT_W = $clog2(Y_WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(Y_WIDTH - 1);

   generate
      if (P_WIDTH != X_WIDTH + Y_WIDTH) begin : g_bad_p_width
         $error("mulu_seq_shiftadd: P_WIDTH must equal X_WIDTH + Y_WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t             state_q,  state_d;
   logic [P_WIDTH-1:0] acc_q,    acc_d;
   logic [P_WIDTH-1:0] mcand_q,  mcand_d;
   logic [Y_WIDTH-1:0] mplier_q, mplier_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic [P_WIDTH-1:0] p_q,      p_d;
   logic               rdy_q,    rdy_d;
   logic               busy_q,   busy_d;
   logic [P_WIDTH-1:0] acc_sum;

   // Running sum including the current partial product.
   assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      p_d      = p_q;
      rdy_d    = rdy_q;
      busy_d   = busy_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               mcand_d  = {{Y_WIDTH{1'b0}}, x};
               mplier_d = y;
               acc_d    = '0;
               cnt_d    = '0;
               rdy_d    = 1'b0;
               busy_d   = 1'b1;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               p_d     = acc_sum;
               rdy_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            rdy_d   = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         p_q      <= '0;
         rdy_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         p_q      <= p_d;
         rdy_q    <= rdy_d;
         busy_q   <= busy_d;
      end
   end

   assign p    = p_q;
   assign rdy  = rdy_q;
   assign busy = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mulu_seq_shiftadd.sv
`default_nettype none
// ============================================================================
// tb_mulu_seq_shiftadd : directed self-checking bench for mulu_seq_shiftadd
// Revision 1.0
// ============================================================================
module tb_mulu_seq_shiftadd;

   logic       clk;
   logic       rst;
   logic [2:0] x;
   logic [2:0] y;
   logic       start;
   logic [5:0] p;
   logic       rdy;
   logic       busy;

   int total;
   int bad;

   mulu_seq_shiftadd #(
      .X_WIDTH(3),
      .Y_WIDTH(3),
      .P_WIDTH(6)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .x    (x),
      .y    (y),
      .start(start),
      .p    (p),
      .rdy  (rdy),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Starts one operation at the current negedge and samples every negedge
   // up to the third RUN edge. Leaves start low and the caller at a negedge.
   task automatic do_op(input logic [2:0] xa, input logic [2:0] ya,
                        output logic acc_busy, output logic acc_rdy,
                        output logic [1:0] mid_rdy,
                        output logic [5:0] pv, output logic rv, output logic bv);
      x = xa;
      y = ya;
      start = 1'b1;
      @(negedge clk);
      acc_busy = busy;
      acc_rdy  = rdy;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         mid_rdy[i] = rdy;
      end
      @(negedge clk);
      pv = p;
      rv = rdy;
      bv = busy;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      x = '0;
      y = '0;
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (p !== 6'd0 || rdy !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: p=%0d rdy=%b busy=%b, want p=0 rdy=0 busy=0", p, rdy, busy);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (rdy !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_release_idle: rdy=%b busy=%b, want 0 0", rdy, busy);
      end
   endtask

   task automatic test_basic();
      logic ab, ar, rv, bv;
      logic [1:0] mr;
      logic [5:0] pv;
      do_op(3'd5, 3'd3, ab, ar, mr, pv, rv, bv);
      total++;
      if (ab !== 1'b1 || ar !== 1'b0) begin
         bad++;
         $display("FAIL basic_accept: busy=%b rdy=%b, want busy=1 rdy=0", ab, ar);
      end
      total++;
      if (mr !== 2'b00) begin
         bad++;
         $display("FAIL basic_latency: rdy before 3rd edge=%b, want 00", mr);
      end
      total++;
      if (pv !== 6'h0F || rv !== 1'b1 || bv !== 1'b0) begin
         bad++;
         $display("FAIL basic_result: p=%0d rdy=%b busy=%b, want p=15 rdy=1 busy=0", pv, rv, bv);
      end
   endtask

   task automatic test_max_and_zero();
      logic ab, ar, rv, bv;
      logic [1:0] mr;
      logic [5:0] pv;
      do_op(3'd7, 3'd7, ab, ar, mr, pv, rv, bv);
      total++;
      if (pv !== 6'h31 || rv !== 1'b1 || mr !== 2'b00 || bv !== 1'b0) begin
         bad++;
         $display("FAIL max_operands: p=%0d rdy=%b mid=%b busy=%b, want p=49 rdy=1 mid=00 busy=0", pv, rv, mr, bv);
      end
      do_op(3'd0, 3'd5, ab, ar, mr, pv, rv, bv);
      total++;
      if (pv !== 6'd0 || rv !== 1'b1 || mr !== 2'b00 || ar !== 1'b0) begin
         bad++;
         $display("FAIL zero_operand: p=%0d rdy=%b mid=%b acc_rdy=%b, want p=0 rdy=1 mid=00 acc_rdy=0", pv, rv, mr, ar);
      end
   endtask

   task automatic test_back_to_back();
      logic ab, ar, rv, bv;
      logic [1:0] mr;
      logic [5:0] pv;
      logic [5:0] want;
      int errs;
      errs = 0;
      for (int xi = 0; xi < 8; xi++) begin
         for (int yi = 0; yi < 8; yi++) begin
            want = 6'(xi * yi);
            do_op(3'(xi), 3'(yi), ab, ar, mr, pv, rv, bv);
            total++;
            if (pv !== want || rv !== 1'b1 || ar !== 1'b0 || ab !== 1'b1 || mr !== 2'b00) begin
               bad++;
               errs++;
               if (errs <= 8)
                  $display("FAIL sweep %0d*%0d: p=%0d rdy=%b acc_rdy=%b acc_busy=%b mid=%b, want p=%0d rdy=1 acc_rdy=0 acc_busy=1 mid=00",
                           xi, yi, pv, rv, ar, ab, mr, want);
            end
         end
      end
   endtask

   task automatic test_start_in_run();
      x = 3'd6;
      y = 3'd5;
      start = 1'b1;
      @(negedge clk);
      x = 3'd1;
      y = 3'd1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      total++;
      if (p !== 6'd30 || rdy !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL start_in_run: p=%0d rdy=%b busy=%b, want p=30 rdy=1 busy=0", p, rdy, busy);
      end
      @(negedge clk);
      total++;
      if (p !== 6'd30 || rdy !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL done_hold: p=%0d rdy=%b busy=%b, want p=30 rdy=1 busy=0", p, rdy, busy);
      end
   endtask

   task automatic test_async_reset();
      int stray;
      x = 3'd7;
      y = 3'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if (p !== 6'd0 || rdy !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL async_reset: p=%0d rdy=%b busy=%b, want p=0 rdy=0 busy=0", p, rdy, busy);
      end
      @(negedge clk);
      rst = 1'b1;
      stray = 0;
      repeat (10) begin
         @(negedge clk);
         if (rdy !== 1'b0 || busy !== 1'b0 || p !== 6'd0) stray++;
      end
      total++;
      if (stray != 0) begin
         bad++;
         $display("FAIL post_reset_idle: %0d cycles with activity, want 0", stray);
      end
   endtask

   task automatic test_operand_stability();
      x = 3'd2;
      y = 3'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         x = 3'($urandom_range(7));
         y = 3'($urandom_range(7));
         @(negedge clk);
      end
      total++;
      if (p !== 6'd6 || rdy !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL operand_stability: p=%0d rdy=%b busy=%b, want p=6 rdy=1 busy=0", p, rdy, busy);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_basic();
      test_max_and_zero();
      test_back_to_back();
      test_start_in_run();
      test_async_reset();
      test_operand_stability();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mulu_seq_shiftadd.md
Name: mulu_seq_shiftadd

Overview:
Sequential unsigned shift-and-add multiplier. It takes X_WIDTH×Y_WIDTH operands from the io_in operand field and produces a P_WIDTH product with a ready flag on io_out. It is the multi-cycle sibling of the combinational unsigned multipliers, and it is the stage that drives the `p`/`rdy` outputs when HAS_READY is configured. One partial product is added per clock, so area stays small at the cost of fixed latency.

Parameters:
X_WIDTH, 3, multiplicand width (bits).
Y_WIDTH, 3, multiplier width (bits); also the number of add/shift iterations.
P_WIDTH, X_WIDTH+Y_WIDTH, product width; overriding it to any other value is illegal.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset; clears all state immediately when low.
x  input  X_WIDTH  multiplicand; sampled only on the edge that accepts start.
y  input  Y_WIDTH  multiplier; sampled only on the edge that accepts start.
start  input  1  request pulse or level; accepted only in IDLE or DONE.
p  output  P_WIDTH  product; registered; valid only while rdy=1.
rdy  output  1  product valid; registered.
busy  output  1  high while in RUN; registered.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - p=0, rdy=0, busy=0.
  - Internal accumulator, multiplicand shift register, multiplier shift register and iteration counter all cleared.
  - Reset release is synchronised by the clock edge, so no action occurs on the release itself.
- States: IDLE, RUN, DONE. Encoding is free, but the unused encoding must recover to IDLE.
- IDLE:
  - start=1 at an edge → load mcand={Y_WIDTH zeros, x}, mplier=y, acc=0, cnt=0; go to RUN; busy=1.
  - start=0 → stay in IDLE.
- RUN, each edge:
  - If mplier[0]=1, then acc=acc+mcand (P_WIDTH-bit add, modulo 2^P_WIDTH; overflow is impossible by construction).
  - mcand shifts left by 1; mplier shifts right by 1; cnt=cnt+1.
  - On the edge where cnt==Y_WIDTH-1: p = final acc value, including this cycle's add; rdy=1; busy=0; go to DONE.
- Latency: the start-accept edge is E0; rdy rises after edge E0+Y_WIDTH (3 RUN edges at the defaults). This latency is fixed and does not depend on operand values; there is no early termination on zero operands.
- start during RUN is ignored, with no effect on the operation in progress.
- DONE:
  - p and rdy hold indefinitely.
  - start=1 at an edge → same load action as in IDLE, plus rdy=0. p may keep its stale value but must not be consumed while rdy=0. The block goes to RUN, giving back-to-back operation with no IDLE cycle.
- Changes on x/y outside the start-accept edge have no effect.
- rst asserted mid-RUN aborts immediately: outputs go to reset values and the partial result is discarded.
- rdy and busy are never both 1. After reset, p changes only on the edge where RUN completes.
- Counter width: $clog2(Y_WIDTH)+1, so that Y_WIDTH equal to a power of two does not wrap.

Test Plan:
- Reset then basic multiply: rst low 2 cycles, release; x=5, y=3, start for one cycle → rdy=1 exactly 3 edges after accept, p=15 (0x0F), busy=0.
- Maximum operands: x=7, y=7 → p=49 (0x31). Then x=0, y=5 → p=0 with the same 3-edge latency.
- Exhaustive sweep: all 64 x,y pairs, each started from DONE back-to-back → every p=x*y. rdy drops on each accept edge and rises 3 edges later. There are no idle gaps.
- Start ignored in RUN: accept x=6, y=5; assert start again with x=1, y=1 during RUN → result p=30, not 1. The block returns to DONE and is not restarted.
- Async reset mid-operation: accept x=7, y=3; pull rst low between edges 1 and 2 → p=0, rdy=0, busy=0 immediately, without waiting for a clock. After release and no start, state stays IDLE and rdy stays 0 for 10 cycles.
- Operand stability: accept x=2, y=3, then change x/y every cycle during RUN → p=6.
